// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> program memory / decoder / operation block bus.
// SINGLE_STEP_EN adds the single-step handshake signals.
interface cpu_sequencer_if #(
    parameter int unsigned PC_W = 5,
    parameter int unsigned IR_W = 6
);
    logic            start;
    logic [IR_W-1:0] instr_in;
    logic            carry_in;
    logic [PC_W-1:0] pc_out;
    logic [IR_W-1:0] ir_out;
    logic            exec_en;
    logic            halted;
    logic            busy;
`ifdef SINGLE_STEP_EN
    logic            step_mode;
    logic            step_req;
    logic            step_ack;
`endif

`ifdef SINGLE_STEP_EN
    modport master (
        input  start, instr_in, carry_in, step_mode, step_req,
        output pc_out, ir_out, exec_en, halted, busy, step_ack
    );
    modport slave (
        output start, instr_in, carry_in, step_mode, step_req,
        input  pc_out, ir_out, exec_en, halted, busy, step_ack
    );
`else
    modport master (
        input  start, instr_in, carry_in,
        output pc_out, ir_out, exec_en, halted, busy
    );
    modport slave (
        output start, instr_in, carry_in,
        input  pc_out, ir_out, exec_en, halted, busy
    );
`endif
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Optional single-step pause/ack mode is enabled with the SINGLE_STEP_EN macro.
module cpu_sequencer #(
    parameter int unsigned     PC_W     = 5,
    parameter int unsigned     IR_W     = 6,
    parameter logic [IR_W-1:0] OP_HLT   = 6'b111111,
    parameter logic [IR_W-1:0] OP_JMP   = 6'b111110,
    parameter logic [IR_W-1:0] OP_JC    = 6'b111101,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic                clk,
    input logic                clr,
    cpu_sequencer_if.master    bus
);

    localparam logic [PC_W-1:0] PcOne = 1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StJtgt,
        StHalt
`ifdef SINGLE_STEP_EN
        , StPause
`endif
    } state_e;

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic [IR_W-1:0] ir_q;
    logic            exec_en_q;
    logic            halted_q;
    logic            busy_q;
`ifdef SINGLE_STEP_EN
    logic            step_ack_q;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            exec_en_q <= 1'b0;
            halted_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SINGLE_STEP_EN
            step_ack_q <= 1'b0;
`endif
        end else begin
            exec_en_q <= 1'b0;
`ifdef SINGLE_STEP_EN
            step_ack_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q <= StFetch;
                        busy_q  <= 1'b1;
                    end
                end
                StFetch: begin
                    ir_q    <= bus.instr_in;
                    state_q <= StDecode;
                end
                StDecode: begin
                    if (ir_q == OP_HLT) begin
                        pc_q     <= pc_q + PcOne;
                        state_q  <= StHalt;
                        halted_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end else if (ir_q == OP_JMP || ir_q == OP_JC) begin
                        pc_q    <= pc_q + PcOne;
                        state_q <= StJtgt;
                    end else begin
                        state_q   <= StExec;
                        exec_en_q <= 1'b1;
                    end
                end
                StExec, StJtgt: begin
                    // In JTGT ir_q is JMP or JC, so carry only matters for JC.
                    if (state_q == StJtgt && (ir_q == OP_JMP || bus.carry_in)) begin
                        pc_q <= bus.instr_in[PC_W-1:0];
                    end else begin
                        pc_q <= pc_q + PcOne;
                    end
`ifdef SINGLE_STEP_EN
                    if (bus.step_mode) begin
                        state_q <= StPause;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= StFetch;
                    end
`else
                    state_q <= StFetch;
`endif
                end
                StHalt: begin
                    if (bus.start) begin
                        state_q  <= StFetch;
                        halted_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
`ifdef SINGLE_STEP_EN
                StPause: begin
                    if (!bus.step_mode) begin
                        state_q <= StFetch;
                        busy_q  <= 1'b1;
                    end else if (bus.step_req) begin
                        // Ack coincides with the FETCH cycle of the released instruction.
                        state_q    <= StFetch;
                        busy_q     <= 1'b1;
                        step_ack_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_out  = pc_q;
    assign bus.ir_out  = ir_q;
    assign bus.exec_en = exec_en_q;
    assign bus.halted  = halted_q;
    assign bus.busy    = busy_q;
`ifdef SINGLE_STEP_EN
    assign bus.step_ack = step_ack_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed-vector bench for cpu_sequencer with a combinational program memory model.
module tb_cpu_sequencer;

    localparam logic [5:0] HLT = 6'b111111;
    localparam logic [5:0] JMP = 6'b111110;
    localparam logic [5:0] JC  = 6'b111101;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic [5:0] pm [32];
    int n_vec = 0;
    int n_mis = 0;
    int exec_cnt = 0;

    cpu_sequencer_if #(.PC_W(5), .IR_W(6)) bus ();

    cpu_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.instr_in = pm[bus.pc_out];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, sampling 1ns after each; counts exec_en pulses.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.exec_en) exec_cnt++;
        end
    endtask

    task automatic kick();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) pm[i] = 6'h00;
        bus.start    = 1'b0;
        bus.carry_in = 1'b0;
`ifdef SINGLE_STEP_EN
        bus.step_mode = 1'b0;
        bus.step_req  = 1'b0;
`endif
        #12;
        check("rst_pc", 32'(bus.pc_out), 32'd0);
        check("rst_ir", 32'(bus.ir_out), 32'd0);
        check("rst_exec", 32'(bus.exec_en), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        clr = 1'b0;

        // op, op, HLT
        pm[0] = 6'h01; pm[1] = 6'h02; pm[2] = HLT;
        kick();
        check("t2_fetch_busy", 32'(bus.busy), 32'd1);
        tick(1);
        check("t2_ir0", 32'(bus.ir_out), 32'h01);
        tick(1);
        check("t2_exec_c3", 32'(bus.exec_en), 32'd1);
        tick(1);
        check("t2_pc_c4", 32'(bus.pc_out), 32'd1);
        tick(2);
        check("t2_exec_c6", 32'(bus.exec_en), 32'd1);
        tick(2);
        check("t2_ir_hlt", 32'(bus.ir_out), 32'(HLT));
        tick(1);
        check("t2_halted", 32'(bus.halted), 32'd1);
        check("t2_halt_pc", 32'(bus.pc_out), 32'd3);
        check("t2_halt_busy", 32'(bus.busy), 32'd0);
        check("t2_exec_count", 32'(exec_cnt), 32'd2);
        tick(2);
        check("t2_halt_hold", 32'(bus.pc_out), 32'd3);

        // clr in the middle of EXEC
        pm[3] = 6'h05;
        kick();
        tick(2);
        check("t1_in_exec", 32'(bus.exec_en), 32'd1);
        clr = 1'b1;
        #1;
        check("t1_exec_drop", 32'(bus.exec_en), 32'd0);
        check("t1_pc_reset", 32'(bus.pc_out), 32'd0);
        check("t1_busy_drop", 32'(bus.busy), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        tick(3);
        check("t1_idle_pc", 32'(bus.pc_out), 32'd0);
        check("t1_idle_busy", 32'(bus.busy), 32'd0);
        check("t1_idle_halted", 32'(bus.halted), 32'd0);

        // JMP 4 -> JMP 20 -> HLT
        pm[0] = JMP; pm[1] = 6'd4; pm[4] = JMP; pm[5] = 6'd20; pm[20] = HLT;
        exec_cnt = 0;
        kick();
        tick(3);
        check("t3_at4", 32'(bus.pc_out), 32'd4);
        tick(3);
        check("t3_at20", 32'(bus.pc_out), 32'd20);
        check("t3_no_exec", 32'(exec_cnt), 32'd0);
        tick(2);
        check("t3_halt_pc", 32'(bus.pc_out), 32'd21);

        // JC taken then not taken
        pm[21] = JC; pm[22] = 6'd9; pm[9] = HLT;
        pm[10] = JC; pm[11] = 6'd9; pm[12] = HLT;
        bus.carry_in = 1'b1;
        kick();
        tick(3);
        check("t4_jc_taken", 32'(bus.pc_out), 32'd9);
        tick(2);
        check("t4_halt10", 32'(bus.pc_out), 32'd10);
        bus.carry_in = 1'b0;
        kick();
        tick(3);
        check("t4_jc_not_taken", 32'(bus.pc_out), 32'd12);
        check("t4_no_exec", 32'(exec_cnt), 32'd0);
        tick(2);
        check("t4_halt13", 32'(bus.pc_out), 32'd13);

        // datapath op at 31 wraps to 0
        pm[13] = JMP; pm[14] = 6'd31; pm[31] = 6'h07; pm[0] = HLT;
        kick();
        tick(3);
        check("t5_at31", 32'(bus.pc_out), 32'd31);
        tick(3);
        check("t5_wrap0", 32'(bus.pc_out), 32'd0);
        check("t5_exec", 32'(exec_cnt), 32'd1);
        tick(2);
        check("t5_halt1", 32'(bus.pc_out), 32'd1);

        // JMP at 31 reads its target from pm[0]
        pm[1] = JMP; pm[2] = 6'd31; pm[31] = JMP; pm[0] = 6'd17; pm[17] = HLT;
        kick();
        tick(3);
        check("t5b_at31", 32'(bus.pc_out), 32'd31);
        tick(3);
        check("t5b_land17", 32'(bus.pc_out), 32'd17);
        tick(2);
        check("t5b_halt18", 32'(bus.pc_out), 32'd18);

`ifdef SINGLE_STEP_EN
        pm[18] = 6'h03; pm[19] = 6'h04; pm[20] = HLT;
        bus.step_mode = 1'b1;
        exec_cnt = 0;
        kick();
        tick(2);
        check("t6_exec1", 32'(bus.exec_en), 32'd1);
        tick(1);
        check("t6_pause_busy", 32'(bus.busy), 32'd0);
        tick(3);
        check("t6_wait_exec", 32'(exec_cnt), 32'd1);
        check("t6_wait_pc", 32'(bus.pc_out), 32'd19);
        check("t6_no_ack", 32'(bus.step_ack), 32'd0);
        bus.step_req = 1'b1;
        tick(1);
        bus.step_req = 1'b0;
        check("t6_ack", 32'(bus.step_ack), 32'd1);
        tick(1);
        check("t6_ack_drop", 32'(bus.step_ack), 32'd0);
        tick(4);
        check("t6_one_more", 32'(exec_cnt), 32'd2);
        check("t6_paused_again", 32'(bus.busy), 32'd0);
        bus.step_mode = 1'b0;
        tick(1);
        check("t6_resume_busy", 32'(bus.busy), 32'd1);
        check("t6_resume_noack", 32'(bus.step_ack), 32'd0);
        tick(2);
        check("t6_halted", 32'(bus.halted), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
